// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: FSM state encoding and SPI mode decode
// Purpose: types and helpers common to the SPI master and the SPI responder.
//   spi_state_t : IDLE / LOAD / SHIFT frame states
//   spi_cpol()  : clock idle level for a mode 0..3 (bit 1 of the mode)
//   spi_cpha()  : clock phase for a mode 0..3 (bit 0 of the mode)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with edge pulses for an asynchronous pin
// Purpose: brings one asynchronous input into the clk domain and flags its transitions.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input
//   dout     : synchronized level
//   rise     : one-cycle pulse, synchronized level went 0 -> 1
//   fall     : one-cycle pulse, synchronized level went 1 -> 0
// Init is the reset level, chosen as the pin's idle level so reset never fakes an edge.
module spi_sync_edge #(
    parameter int   Stages = 2,
    parameter logic Init   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [Stages-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {Stages{Init}};
            prev  <= Init;
        end else begin
            chain <= {chain[Stages-2:0], din};
            prev  <= chain[Stages-1];
        end
    end

    assign dout = chain[Stages-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder: oversampled pins, TX holding register, RX word pulse
// Purpose: far end of the SPI master. SCLK/CS_n/MOSI are oversampled in clk; a word from
//   the TX holding register is shifted out MSB first on MISO while MOSI is shifted in.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   i_SPI_sclk/cs_n/mosi     : SPI pins from the master (asynchronous)
//   o_SPI_miso               : slave-out data, 0 outside a frame
//   i_TX_data/i_TX_valid     : word offer into the holding register
//   o_TX_ready               : holding register empty
//   o_RX_data/o_RX_valid     : last received word and its one-cycle update pulse
//   o_busy                   : synchronized CS_n is low
// Option SPI_SLAVE_STATUS_EN adds o_TX_underrun and o_RX_abort status pulses.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_mode    = 0,
    parameter int Data_width  = 8,
    parameter int Sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_SPI_sclk,
    input  logic                  i_SPI_cs_n,
    input  logic                  i_SPI_mosi,
    output logic                  o_SPI_miso,
    input  logic [Data_width-1:0] i_TX_data,
    input  logic                  i_TX_valid,
    output logic                  o_TX_ready,
    output logic [Data_width-1:0] o_RX_data,
    output logic                  o_RX_valid,
    output logic                  o_busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    output logic                  o_TX_underrun,
    output logic                  o_RX_abort
`endif
);

    localparam logic            CPOL     = spi_cpol(SPI_mode);
    localparam logic            CPHA     = spi_cpha(SPI_mode);
    localparam int              CW       = $clog2(Data_width) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(Data_width - 1);

    logic sclk_s, sclk_rise, sclk_fall, sclk_edge, lead, trail;
    logic cs_s, cs_rise, cs_fall, mosi_s;
    logic [Sync_stages-1:0] mosi_chain;

    spi_sync_edge #(.Stages(Sync_stages), .Init(CPOL)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (i_SPI_sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.Stages(Sync_stages), .Init(1'b1)) u_cs_sync (
        .clk (clk), .rst (rst), .din (i_SPI_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI has the same depth as SCLK so the sampled bit lines up with the edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_chain <= '0;
        else     mosi_chain <= {mosi_chain[Sync_stages-2:0], i_SPI_mosi};
    end
    assign mosi_s = mosi_chain[Sync_stages-1];

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead      = sclk_edge & (sclk_s != CPOL);
    assign trail     = sclk_edge & (sclk_s == CPOL);

    spi_state_t state, state_n;
    logic load_word, sample_en, shift_en, frame_end, word_done, reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_word = 1'b0;
        sample_en = 1'b0;
        shift_en  = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_n = LOAD;
            LOAD: begin
                load_word = 1'b1;
                if (cs_rise) begin
                    frame_end = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                sample_en = CPHA ? trail : lead;
                shift_en  = CPHA ? lead  : trail;
                if (cs_rise) begin
                    frame_end = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [Data_width-1:0] hold_data, shift_tx, shift_rx, rx_data, next_word;
    logic                  hold_full, miso, rx_valid;
    logic [CW-1:0]         bit_cnt;

    assign next_word = hold_full ? hold_data : '0;
    assign word_done = sample_en && (bit_cnt == LAST_BIT);
    // A word finishing as CS_n rises still completes, but no follow-on word is started,
    // so the holding register is left for the next frame.
    assign reload    = load_word || (word_done && !frame_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            miso      <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (i_TX_valid && !hold_full) begin
                hold_data <= i_TX_data;
                hold_full <= 1'b1;
            end
            if (shift_en) begin
                miso     <= shift_tx[Data_width-1];
                shift_tx <= shift_tx << 1;
            end
            if (sample_en) begin
                shift_rx <= {shift_rx[Data_width-2:0], mosi_s};
                bit_cnt  <= bit_cnt + 1'b1;
                if (word_done) begin
                    rx_data  <= {shift_rx[Data_width-2:0], mosi_s};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end
            end
            if (reload) begin
                if (hold_full) hold_full <= 1'b0;
                // CPHA=0 must show the MSB before the first edge, so it is presented
                // here and the shifter starts one bit ahead. Mid-frame reloads leave
                // that to the trailing edge that follows the last sample.
                if (load_word && !CPHA) begin
                    miso     <= next_word[Data_width-1];
                    shift_tx <= next_word << 1;
                end else begin
                    shift_tx <= next_word;
                end
                bit_cnt <= '0;
            end
            if (frame_end) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    // Underrun is reported when an empty-loaded word actually begins (its first sample),
    // so the idle reload after the last word of a frame does not raise it.
    logic urun_pend, tx_underrun, rx_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            urun_pend   <= 1'b0;
            tx_underrun <= 1'b0;
            rx_abort    <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_abort    <= frame_end && (bit_cnt != '0) && !word_done;
            if (reload) begin
                urun_pend <= !hold_full;
            end else if (sample_en && (bit_cnt == '0) && urun_pend) begin
                tx_underrun <= 1'b1;
                urun_pend   <= 1'b0;
            end
            if (frame_end) urun_pend <= 1'b0;
        end
    end

    assign o_TX_underrun = tx_underrun;
    assign o_RX_abort    = rx_abort;
`endif

    assign o_SPI_miso = miso;
    assign o_TX_ready = !hold_full;
    assign o_RX_data  = rx_data;
    assign o_RX_valid = rx_valid;
    assign o_busy     = !cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave in all four SPI modes
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] sclk, cs_n, tx_valid, miso, tx_ready, rx_valid, busy;
    logic       mosi;
    logic [7:0] tx_data;
    logic [7:0] rx_data [4];
`ifdef SPI_SLAVE_STATUS_EN
    logic [3:0] tx_underrun, rx_abort;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_mode(g), .Data_width(W), .Sync_stages(2)) dut (
            .clk          (clk),
            .rst          (rst),
            .i_SPI_sclk   (sclk[g]),
            .i_SPI_cs_n   (cs_n[g]),
            .i_SPI_mosi   (mosi),
            .o_SPI_miso   (miso[g]),
            .i_TX_data    (tx_data),
            .i_TX_valid   (tx_valid[g]),
            .o_TX_ready   (tx_ready[g]),
            .o_RX_data    (rx_data[g]),
            .o_RX_valid   (rx_valid[g]),
            .o_busy       (busy[g])
`ifdef SPI_SLAVE_STATUS_EN
            ,
            .o_TX_underrun(tx_underrun[g]),
            .o_RX_abort   (rx_abort[g])
`endif
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int         rx_cnt [4];
    int         urun_cnt [4];
    int         abort_cnt [4];
    logic [7:0] rx_q0 [$];

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_cnt[i] = 0; urun_cnt[i] = 0; abort_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i] === 1'b1) rx_cnt[i]++;
`ifdef SPI_SLAVE_STATUS_EN
            if (tx_underrun[i] === 1'b1) urun_cnt[i]++;
            if (rx_abort[i] === 1'b1) abort_cnt[i]++;
`endif
        end
        if (rx_valid[0] === 1'b1) rx_q0.push_back(rx_data[0]);
    end

    logic [7:0] m_tx [3];
    logic [7:0] m_rx [3];

    task automatic tx_push(input int m, input logic [7:0] d);
        int n = 0;
        while (tx_ready[m] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready[m], 1);
        @(negedge clk);
        tx_data     = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    // SPI master; stop_bits > 0 returns with CS_n still low after that many bits.
    task automatic master_frame(input int m, input int nw, input int stop_bits);
        logic cpol, cpha;
        int   nb;
        cpol = m[1];
        cpha = m[0];
        nb   = 0;
        @(negedge clk);
        cs_n[m] = 1'b0;
        #(2 * HALF);
        for (int w = 0; w < nw; w++) begin
            m_rx[w] = '0;
            for (int b = W - 1; b >= 0; b--) begin
                if (!cpha) begin
                    mosi = m_tx[w][b];
                    #HALF;
                    m_rx[w][b] = miso[m];
                    sclk[m] = ~cpol;
                    #HALF;
                    sclk[m] = cpol;
                end else begin
                    sclk[m] = ~cpol;
                    mosi = m_tx[w][b];
                    #HALF;
                    m_rx[w][b] = miso[m];
                    sclk[m] = cpol;
                    #HALF;
                end
                nb++;
                if (stop_bits != 0 && nb == stop_bits) return;
            end
        end
        #HALF;
        cs_n[m] = 1'b1;
        #(4 * HALF);
    endtask

    typedef struct {
        int         mode;
        logic       preload;
        logic [7:0] mo;
        logic [7:0] so;
        logic [7:0] exp_master;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [5];
    int   c0, u0, a0, m;

    initial begin
        vecs[0] = '{0, 1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
        vecs[1] = '{1, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[2] = '{2, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[3] = '{3, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[4] = '{0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF};

        rst = 1'b1; cs_n = 4'hF; sclk = 4'b1100; mosi = 1'b0;
        tx_data = '0; tx_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            check("reset_miso", miso[i], 0);
            check("reset_tx_ready", tx_ready[i], 1);
            check("reset_rx_data", rx_data[i], 0);
            check("reset_rx_valid", rx_valid[i], 0);
            check("reset_busy", busy[i], 0);
        end

        for (int v = 0; v < 5; v++) begin
            m  = vecs[v].mode;
            c0 = rx_cnt[m];
            u0 = urun_cnt[m];
            if (vecs[v].preload) tx_push(m, vecs[v].so);
            check("ready_before_frame", tx_ready[m], !vecs[v].preload);
            m_tx[0] = vecs[v].mo;
            master_frame(m, 1, 0);
            check("vec_master_rx", m_rx[0], vecs[v].exp_master);
            check("vec_rx_pulses", rx_cnt[m] - c0, 1);
            check("vec_rx_data", rx_data[m], vecs[v].exp_rx);
            check("vec_ready_after", tx_ready[m], 1);
            check("vec_busy_after", busy[m], 0);
            check("vec_miso_idle", miso[m], 0);
`ifdef SPI_SLAVE_STATUS_EN
            check("vec_underrun", urun_cnt[m] - u0, vecs[v].preload ? 0 : 1);
`endif
        end

        // Three back-to-back words in one frame, holding register refilled on ready.
        c0 = rx_cnt[0];
        rx_q0.delete();
        m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
        tx_push(0, 8'h9C);
        fork
            master_frame(0, 3, 0);
            begin
                tx_push(0, 8'h4E);
                tx_push(0, 8'hE7);
            end
        join
        check("b2b_rx_pulses", rx_cnt[0] - c0, 3);
        check("b2b_rx_q_size", rx_q0.size(), 3);
        for (int i = 0; i < rx_q0.size() && i < 3; i++)
            check("b2b_rx_order", rx_q0[i], m_tx[i]);
        check("b2b_master_rx0", m_rx[0], 8'h9C);
        check("b2b_master_rx1", m_rx[1], 8'h4E);
        check("b2b_master_rx2", m_rx[2], 8'hE7);

        // CS_n raised after 5 bits: partial word discarded.
        c0 = rx_cnt[0];
        a0 = abort_cnt[0];
        m_tx[0] = 8'hF0;
        master_frame(0, 1, 5);
        #HALF;
        cs_n[0] = 1'b1;
        #(4 * HALF);
        check("abort_no_pulse", rx_cnt[0] - c0, 0);
        check("abort_rx_held", rx_data[0], 8'h33);
        check("abort_miso", miso[0], 0);
`ifdef SPI_SLAVE_STATUS_EN
        check("abort_flag", abort_cnt[0] - a0, 1);
`endif
        c0 = rx_cnt[0];
        m_tx[0] = 8'h5A;
        master_frame(0, 1, 0);
        check("after_abort_pulse", rx_cnt[0] - c0, 1);
        check("after_abort_rx", rx_data[0], 8'h5A);

        // Reset asserted after 3 bits of a frame.
        tx_push(0, 8'h66);
        m_tx[0] = 8'h99;
        master_frame(0, 1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_miso", miso[0], 0);
        check("midrst_ready", tx_ready[0], 1);
        check("midrst_rx_data", rx_data[0], 0);
        check("midrst_rx_valid", rx_valid[0], 0);
        check("midrst_busy", busy[0], 0);
        cs_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        c0 = rx_cnt[0];
        tx_push(0, 8'h3A);
        m_tx[0] = 8'hC3;
        master_frame(0, 1, 0);
        check("postrst_pulse", rx_cnt[0] - c0, 1);
        check("postrst_rx", rx_data[0], 8'hC3);
        check("postrst_master_rx", m_rx[0], 8'h3A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
